// File: rtl/mips_mem_ctrl.sv
// mips_mem_ctrl: bridges a core load/store request port to a word-wide
// data memory with a fixed access latency.
//   - Loads: one read phase, then the addressed byte or half is extracted
//     and sign- or zero-extended.
//   - Word stores: one write phase.
//   - Byte and half stores: read-modify-write. The word is read, the
//     addressed lane is replaced, and the merged word is written back.
//   - Misaligned accesses and the reserved size are rejected without any
//     memory access.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_write, req_size, req_signed request attributes
//   req_addr, req_wdata             request address and right-justified store data
//   rsp_valid, rsp_rdata, rsp_err   one-cycle completion pulse with result
//   mem_address, write_data         word address and write word to memory
//   sig_mem_read, sig_mem_write     memory strobes, each held MEM_LAT cycles
//   read_data                       word returned by memory
// Parameter:
//   MEM_LAT  cycles each strobe is held (1..15)
module mips_mem_ctrl #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_address,
    output logic [31:0] write_data,
    output logic        sig_mem_read,
    output logic        sig_mem_write,
    input  logic [31:0] read_data
);

    typedef enum logic [2:0] {IDLE, RD, RMW_RD, RMW_WR, WR, RSP} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [3:0] LAST    = 4'(MEM_LAT - 1);

    state_t      r_state, w_next;
    logic [3:0]  r_cnt;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;   // store data; replaced by the merged word in RMW
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_acc;
    logic        w_err_in;
    logic        w_last;
    logic [31:0] w_word_addr;

    // Big-endian lane order: offset 0 is the most significant byte.
    function automatic logic [31:0] f_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (sz)
            SZ_BYTE: res = {{24{sgn & b[7]}}, b};
            SZ_HALF: res = {{16{sgn & h[15]}}, h};
            default: res = w;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] w, input logic [31:0] wd,
                                            input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] res;
        if (sz == SZ_BYTE) begin
            case (off)
                2'd0:    res = {wd[7:0], w[23:0]};
                2'd1:    res = {w[31:24], wd[7:0], w[15:0]};
                2'd2:    res = {w[31:16], wd[7:0], w[7:0]};
                default: res = {w[31:8], wd[7:0]};
            endcase
        end else if (sz == SZ_HALF) begin
            res = off[1] ? {w[31:16], wd[15:0]} : {wd[15:0], w[15:0]};
        end else begin
            res = wd;
        end
        return res;
    endfunction

    assign w_acc       = req_valid && (r_state == IDLE);
    assign w_err_in    = (req_size == 2'b11) ||
                         ((req_size == SZ_HALF) && req_addr[0]) ||
                         ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign w_last      = (r_cnt == LAST);
    assign w_word_addr = {r_addr[31:2], 2'b00};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state and outputs. Every output is decoded from registered state,
    // so an asynchronous reset clears all outputs immediately.
    always_comb begin
        w_next        = r_state;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        rsp_rdata     = 32'h0;
        rsp_err       = 1'b0;
        mem_address   = 32'h0;
        write_data    = 32'h0;
        sig_mem_read  = 1'b0;
        sig_mem_write = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_err_in)               w_next = RSP;
                    else if (!req_write)        w_next = RD;
                    else if (req_size == SZ_WORD) w_next = WR;
                    else                        w_next = RMW_RD;
                end
            end
            RD: begin
                sig_mem_read = 1'b1;
                mem_address  = w_word_addr;
                if (w_last) w_next = RSP;
            end
            RMW_RD: begin
                sig_mem_read = 1'b1;
                mem_address  = w_word_addr;
                if (w_last) w_next = RMW_WR;
            end
            RMW_WR: begin
                sig_mem_write = 1'b1;
                mem_address   = w_word_addr;
                write_data    = r_wdata;
                if (w_last) w_next = RSP;
            end
            WR: begin
                sig_mem_write = 1'b1;
                mem_address   = w_word_addr;
                write_data    = r_wdata;
                if (w_last) w_next = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                rsp_rdata = r_rdata;
                rsp_err   = r_err;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Request capture, strobe counter and data path registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= 4'd0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_rdata  <= 32'h0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        r_cnt    <= 4'd0;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_rdata  <= 32'h0;  // stays 0 for stores and errors
                        r_err    <= w_err_in;
                    end
                end
                RD, RMW_RD, RMW_WR, WR: begin
                    r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
                    if (w_last && (r_state == RD))
                        r_rdata <= f_load(read_data, r_size, r_addr[1:0], r_signed);
                    // Merge on the last read cycle so the write phase drives a
                    // stable word for its whole strobe.
                    if (w_last && (r_state == RMW_RD))
                        r_wdata <= f_merge(read_data, r_wdata, r_size, r_addr[1:0]);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mem_ctrl.sv
module tb_mips_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_address, write_data, read_data;
    logic        sig_mem_read, sig_mem_write;

    logic        b_req_valid, b_req_ready, b_req_write, b_req_signed;
    logic [1:0]  b_req_size;
    logic [31:0] b_req_addr, b_req_wdata;
    logic        b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;
    logic [31:0] b_mem_address, b_write_data, b_read_data;
    logic        b_sig_mem_read, b_sig_mem_write;

    logic [31:0] mem [0:63];
    assign read_data   = mem[mem_address[7:2]];
    assign b_read_data = 32'h0;

    always #5 clk = ~clk;

    mips_mem_ctrl #(.MEM_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_address(mem_address), .write_data(write_data),
        .sig_mem_read(sig_mem_read), .sig_mem_write(sig_mem_write),
        .read_data(read_data)
    );

    mips_mem_ctrl #(.MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_size(b_req_size), .req_signed(b_req_signed), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err), .mem_address(b_mem_address), .write_data(b_write_data),
        .sig_mem_read(b_sig_mem_read), .sig_mem_write(b_sig_mem_write),
        .read_data(b_read_data)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init;
        logic [31:0] exp_rd;
        logic        err;
        logic [31:0] exp_mem;
        int          lat;
        int          nrd;
        int          nwr;
    } vec_t;

    exp_t        sbq[$];
    vec_t        vt[14];
    int          checks = 0, failures = 0;
    int          ncyc = 0, nrd = 0, nwr = 0, nacc = 0;
    int          bwr = 0, brd = 0, brsp = 0, brsp_cyc = 0;
    logic [31:0] cur_addr = 32'h0;

    // Handshakes are counted on the accepting edge itself.
    always @(posedge clk) if (req_valid && req_ready) nacc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    // Advance to the next falling edge and monitor both controllers there.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        ncyc++;
        if (sig_mem_read || sig_mem_write) begin
            chk("strobe_excl", 32'(sig_mem_read & sig_mem_write), 32'h0);
            chk("mem_address", mem_address, {cur_addr[31:2], 2'b00});
        end
        if (sig_mem_read) nrd++;
        if (sig_mem_write) begin
            nwr++;
            mem[mem_address[7:2]] = write_data;
        end
        if (rsp_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected none (cycle %0d)", ncyc);
            end else begin
                e = sbq.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("rsp_latency", 32'(ncyc - e.acc), 32'(e.lat));
            end
        end
        if (b_sig_mem_read) brd++;
        if (b_sig_mem_write) begin
            bwr++;
            chk("b_mem_address", b_mem_address, 32'h40);
            chk("b_write_data", b_write_data, 32'h55AA55AA);
        end
        if (b_rsp_valid) begin
            brsp++;
            brsp_cyc = ncyc;
            chk("b_rsp_err", 32'(b_rsp_err), 32'h0);
        end
    endtask

    task automatic drive(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
    endtask

    // Wait (bounded) for req_ready, then record the expectation for the
    // handshake that the next rising edge completes.
    task automatic push_when_ready(input logic [31:0] rd, input logic err, input int lat);
        exp_t e;
        for (int k = 0; k < 50 && !req_ready; k++) tick();
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1");
        end
        e.rdata = rd; e.err = err; e.lat = lat; e.acc = ncyc;
        sbq.push_back(e);
        tick();
    endtask

    task automatic wait_done();
        for (int k = 0; k < 100 && sbq.size() != 0; k++) tick();
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_timeout: got %0d pending expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    int acc0, acc1, acc2, nacc0;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        //          w     sz     sg    addr          wdata          init           exp_rd         err   exp_mem        lat nrd nwr
        vt[0]  = '{1'b0, 2'b10, 1'b0, 32'h00000010, 32'h0,         32'h80FF1234, 32'h80FF1234, 1'b0, 32'h80FF1234, 2, 1, 0};
        vt[1]  = '{1'b0, 2'b00, 1'b1, 32'h00000011, 32'h0,         32'h80FF1234, 32'hFFFFFFFF, 1'b0, 32'h80FF1234, 2, 1, 0};
        vt[2]  = '{1'b0, 2'b01, 1'b0, 32'h00000012, 32'h0,         32'h80FF1234, 32'h00001234, 1'b0, 32'h80FF1234, 2, 1, 0};
        vt[3]  = '{1'b0, 2'b00, 1'b0, 32'h00000010, 32'h0,         32'h80FF1234, 32'h00000080, 1'b0, 32'h80FF1234, 2, 1, 0};
        vt[4]  = '{1'b0, 2'b00, 1'b1, 32'h00000010, 32'h0,         32'h80FF1234, 32'hFFFFFF80, 1'b0, 32'h80FF1234, 2, 1, 0};
        vt[5]  = '{1'b0, 2'b01, 1'b1, 32'h00000010, 32'h0,         32'h80FF1234, 32'hFFFF80FF, 1'b0, 32'h80FF1234, 2, 1, 0};
        vt[6]  = '{1'b1, 2'b00, 1'b0, 32'h00000013, 32'h000000AB, 32'h11223344, 32'h0,         1'b0, 32'h112233AB, 3, 1, 1};
        vt[7]  = '{1'b1, 2'b01, 1'b0, 32'h00000020, 32'hDEADBEEF, 32'h11223344, 32'h0,         1'b0, 32'hBEEF3344, 3, 1, 1};
        vt[8]  = '{1'b1, 2'b00, 1'b0, 32'h00000021, 32'h123456CC, 32'h11223344, 32'h0,         1'b0, 32'h11CC3344, 3, 1, 1};
        vt[9]  = '{1'b1, 2'b10, 1'b0, 32'h00000024, 32'hCAFEF00D, 32'h00000000, 32'h0,         1'b0, 32'hCAFEF00D, 2, 0, 1};
        vt[10] = '{1'b0, 2'b10, 1'b0, 32'h00000016, 32'h0,         32'h80FF1234, 32'h0,         1'b1, 32'h80FF1234, 1, 0, 0};
        vt[11] = '{1'b0, 2'b11, 1'b0, 32'h00000018, 32'h0,         32'h80FF1234, 32'h0,         1'b1, 32'h80FF1234, 1, 0, 0};
        vt[12] = '{1'b1, 2'b01, 1'b0, 32'h00000011, 32'h0000FFFF, 32'h11223344, 32'h0,         1'b1, 32'h11223344, 1, 0, 0};
        vt[13] = '{1'b1, 2'b10, 1'b0, 32'h0000002A, 32'hFFFFFFFF, 32'h11223344, 32'h0,         1'b1, 32'h11223344, 1, 0, 0};

        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_size = 2'b00; b_req_signed = 1'b0;
        b_req_addr = 32'h0; b_req_wdata = 32'h0;
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'h1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_strobes", 32'({sig_mem_read, sig_mem_write}), 32'h0);
        chk("reset_mem_address", mem_address, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // Table of single operations
        for (int i = 0; i < 14; i++) begin
            mem[vt[i].addr[7:2]] = vt[i].init;
            cur_addr = vt[i].addr;
            nrd = 0;
            nwr = 0;
            drive(vt[i].w, vt[i].sz, vt[i].sg, vt[i].addr, vt[i].wdata);
            push_when_ready(vt[i].exp_rd, vt[i].err, vt[i].lat);
            req_valid = 1'b0;
            wait_done();
            chk($sformatf("v%0d_mem", i), mem[vt[i].addr[7:2]], vt[i].exp_mem);
            chk($sformatf("v%0d_nrd", i), 32'(nrd), 32'(vt[i].nrd));
            chk($sformatf("v%0d_nwr", i), 32'(nwr), 32'(vt[i].nwr));
        end

        // Three back-to-back loads with req_valid held high throughout
        mem[4] = 32'h80FF1234;
        cur_addr = 32'h10;
        nacc0 = nacc;
        drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        push_when_ready(32'h80FF1234, 1'b0, 2);
        acc0 = sbq[0].acc;
        chk("b2b_busy0", 32'(req_ready), 32'h0);
        drive(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
        push_when_ready(32'hFFFFFFFF, 1'b0, 2);
        acc1 = ncyc - 1;
        chk("b2b_busy1", 32'(req_ready), 32'h0);
        drive(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        push_when_ready(32'h00001234, 1'b0, 2);
        acc2 = ncyc - 1;
        req_valid = 1'b0;
        wait_done();
        chk("b2b_accepts", 32'(nacc - nacc0), 32'h3);
        chk("b2b_gap01", 32'(acc1 - acc0), 32'h3);
        chk("b2b_gap12", 32'(acc2 - acc1), 32'h3);

        // Reset while a half store is in its read phase
        mem[12] = 32'h11223344;
        cur_addr = 32'h30;
        nwr = 0;
        tick();
        drive(1'b1, 2'b01, 1'b0, 32'h30, 32'h0000BEEF);
        for (int k = 0; k < 50 && !req_ready; k++) tick();
        tick();
        req_valid = 1'b0;
        chk("rmw_rd_strobe", 32'(sig_mem_read), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", 32'(req_ready), 32'h1);
        chk("rst_mid_rsp", 32'({rsp_valid, rsp_err}), 32'h0);
        chk("rst_mid_rdata", rsp_rdata, 32'h0);
        chk("rst_mid_addr", mem_address, 32'h0);
        chk("rst_mid_wdata", write_data, 32'h0);
        chk("rst_mid_strobes", 32'({sig_mem_read, sig_mem_write}), 32'h0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk("rst_mid_nwr", 32'(nwr), 32'h0);
        chk("rst_mid_mem", mem[12], 32'h11223344);
        drive(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
        push_when_ready(32'h11223344, 1'b0, 2);
        req_valid = 1'b0;
        wait_done();

        // MEM_LAT=3 word store on the second controller
        chk("b_ready", 32'(b_req_ready), 32'h1);
        b_req_write = 1'b1; b_req_size = 2'b10; b_req_addr = 32'h40;
        b_req_wdata = 32'h55AA55AA; b_req_valid = 1'b1;
        acc0 = ncyc;
        tick();
        b_req_valid = 1'b0;
        for (int k = 0; k < 20 && brsp == 0; k++) tick();
        chk("b_rsp_count", 32'(brsp), 32'h1);
        chk("b_rsp_latency", 32'(brsp_cyc - acc0), 32'h4);
        chk("b_nwr", 32'(bwr), 32'h3);
        chk("b_nrd", 32'(brd), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
